imem_loader: RTL and testbench

Boot-time writer for the processor's byte-wide instruction memory (32 locations, 8 bits each). It accepts a framed byte stream, checks it, and writes the program into memory in the byte order the fetch path reads: address pc holds bits 31:24 of the instruction, pc+3 holds bits 7:0. Memory locations the program does not use are cleared to zero. The processor is held stalled (PC and register writes frozen) until a complete, checksum-clean image has been written.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader.sv | 199 +++++++++++++++++++
 tb/tb_imem_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_ZERO = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  // Default instruction memory size in bytes (multiple of 4).
  localparam int DEPTH_DEF = 32;

  // Largest legal word count in a frame for the default memory size.
  localparam int MAX_WORDS = DEPTH_DEF / 4;

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: receives LEN / payload / CSUM frames, writes the payload
// into instruction memory MSB-first, zero-fills the unused tail and holds the
// core stalled until a checksum-clean image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  // One extra pointer bit so that "pointer == DEPTH" is representable.
  localparam int                PTR_W   = ADDR_W + 1;
  localparam logic [7:0]        MAX_N   = 8'(DEPTH / 4);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0]  DEPTH_P = PTR_W'(DEPTH);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   nbytes_q, nbytes_d;
  logic [7:0]         csum_q, csum_d;
  logic               byte_ready_q, byte_ready_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic               core_hold_q, core_hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               accept_s;

  assign accept_s   = byte_valid & byte_ready_q;

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign err        = err_q;

  // Next-state, datapath and registered-output computation for the loader FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    nbytes_d    = nbytes_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LEN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LEN: begin
        if (accept_s) begin
          if ((byte_data == 8'h00) || (byte_data > MAX_N)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d  = ST_DATA;
            ptr_d    = '0;
            csum_d   = 8'h00;
            // Word count times four; fits because N <= DEPTH/4.
            nbytes_d = {byte_data[ADDR_W-2:0], 2'b00};
          end
        end else begin
          state_d = ST_LEN;
        end
      end

      ST_DATA: begin
        if (accept_s) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q[ADDR_W-1:0];
          mem_wdata_d = byte_data;
          ptr_d       = ptr_q + PTR_ONE;
          csum_d      = csum_q ^ byte_data;
          if (ptr_q == (nbytes_q - PTR_ONE)) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_CSUM: begin
        if (accept_s) begin
          if (byte_data != csum_q) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (nbytes_q == DEPTH_P) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            // First zero-fill write is issued together with CSUM acceptance.
            state_d     = ST_ZERO;
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q[ADDR_W-1:0];
            mem_wdata_d = 8'h00;
            ptr_d       = ptr_q + PTR_ONE;
          end
        end else begin
          state_d = ST_CSUM;
        end
      end

      ST_ZERO: begin
        if (ptr_q == DEPTH_P) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d     = ST_ZERO;
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q[ADDR_W-1:0];
          mem_wdata_d = 8'h00;
          ptr_d       = ptr_q + PTR_ONE;
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d = ST_LEN;
          done_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_ERR: begin
        if (start) begin
          state_d = ST_LEN;
          err_d   = 1'b0;
        end else begin
          state_d = ST_ERR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready and hold are registered views of the state being entered.
    byte_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
    core_hold_d  = (state_d != ST_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      nbytes_q     <= '0;
      csum_q       <= 8'h00;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'h00;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      nbytes_q     <= nbytes_d;
      csum_q       <= csum_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_hold_q  <= core_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a frame-level model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = DEPTH_DEF;

  logic       clk;
  logic       rst;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       core_hold;
  logic       done;
  logic       err;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .err(err)
  );

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_acc = 0;
  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] model_mem[DEPTH];
  logic [7:0] tb_mem[DEPTH];
  bit         exp_done;
  int         exp_delay;
  logic [7:0] exp_csum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: every write must be the next one the model predicts.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", {27'd0, mem_addr}, {27'd0, w.a});
          chk("wr_data", {24'd0, mem_wdata}, {24'd0, w.d});
        end
        tb_mem[mem_addr] = mem_wdata;
      end
      chk("hold_is_not_done", {31'd0, core_hold}, {31'd0, ~done});
      chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
    end
  end

  // Build the frame and predict writes, final status and memory image.
  task automatic plan(input int n, input bit use_ovr, input logic [7:0] ovr);
    logic [7:0] cs;
    logic [7:0] sent;
    frame_q.delete();
    frame_q.push_back(8'(n));
    exp_delay = 0;
    if (n < 1 || n > MAX_WORDS) begin
      exp_done = 1'b0;
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      cs = cs ^ pay_q[i];
      frame_q.push_back(pay_q[i]);
      exp_q.push_back('{a: 5'(i), d: pay_q[i]});
      model_mem[i] = pay_q[i];
    end
    exp_csum = cs;
    sent = use_ovr ? ovr : cs;
    frame_q.push_back(sent);
    if (sent != cs) begin
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b1;
      exp_delay = DEPTH - 4 * n;
      for (int a = 4 * n; a < DEPTH; a++) begin
        exp_q.push_back('{a: 5'(a), d: 8'h00});
        model_mem[a] = 8'h00;
      end
    end
  endtask

  // Present one byte from a negedge and return at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      chk("handshake_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i]);
      if (gap && i != frame_q.size() - 1) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", {31'd0, byte_ready}, 32'd1);
    chk("start_hold", {31'd0, core_hold}, 32'd1);
    chk("start_done_clear", {31'd0, done}, 32'd0);
    chk("start_err_clear", {31'd0, err}, 32'd0);
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    while (!(done || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
      chk({name, "_err"}, {31'd0, err}, {31'd0, ~exp_done});
      chk({name, "_hold"}, {31'd0, core_hold}, {31'd0, ~exp_done});
      chk({name, "_delay"}, 32'(cyc - last_acc), 32'(exp_delay));
    end
    chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_image(input string name);
    for (int i = 0; i < DEPTH; i++) chk(name, {24'd0, tb_mem[i]}, {24'd0, model_mem[i]});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i] = 8'hEE;
      model_mem[i] = 8'hEE;
    end
    #12;
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_hold", {31'd0, core_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-word image with zero fill.
    pulse_start();
    pay_q = '{8'h8C, 8'h01, 8'h00, 8'h04};
    plan(1, 1'b0, 8'h00);
    chk("model_csum", {24'd0, exp_csum}, 32'h89);
    chk("model_zero_cycles", 32'(exp_delay), 32'd28);
    chk("model_writes", 32'(exp_q.size()), 32'd32);
    send_frame(1'b0);
    wait_result("len1");
    check_image("len1_mem");
    chk("len1_instr", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}, 32'h8C010004);

    // LEN = 0 and LEN = 9 are rejected with no writes.
    do_reset();
    pulse_start();
    plan(0, 1'b0, 8'h00);
    send_frame(1'b0);
    wait_result("len0");
    repeat (4) @(negedge clk);
    chk("len0_err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    pulse_start();
    plan(9, 1'b0, 8'h00);
    send_frame(1'b0);
    wait_result("len9");

    // Start from ERR, bad checksum: data writes only, then err.
    pulse_start();
    pay_q = '{8'h8C, 8'h01, 8'h00, 8'h04};
    plan(1, 1'b1, 8'h00);
    send_frame(1'b0);
    wait_result("badcs");
    repeat (3) @(negedge clk);
    chk("badcs_done_low", {31'd0, done}, 32'd0);

    // Full image with byte_valid toggling: 32 writes, no zero fill.
    pulse_start();
    pay_q.delete();
    for (int i = 0; i < 32; i++) pay_q.push_back(8'((i * 37 + 5) & 255));
    plan(8, 1'b0, 8'h00);
    chk("model_full_writes", 32'(exp_q.size()), 32'd32);
    send_frame(1'b1);
    wait_result("len8");
    check_image("len8_mem");

    // Asynchronous reset in the middle of DATA, then a clean reload.
    pulse_start();
    pay_q.delete();
    for (int i = 0; i < 32; i++) pay_q.push_back(8'(255 - i * 3));
    plan(8, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) send_byte(frame_q[i]);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, byte_ready}, 32'd0);
    chk("arst_we", {31'd0, mem_we}, 32'd0);
    chk("arst_addr", {27'd0, mem_addr}, 32'd0);
    chk("arst_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("arst_hold", {31'd0, core_hold}, 32'd1);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = tb_mem[i];
    pulse_start();
    pay_q.delete();
    for (int i = 0; i < 32; i++) pay_q.push_back(8'((i * 11 + 100) & 255));
    plan(8, 1'b0, 8'h00);
    send_frame(1'b0);
    wait_result("reload");
    check_image("reload_mem");

    // Reload from DONE with a two-word image.
    pulse_start();
    pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    plan(2, 1'b0, 8'h00);
    chk("model_len2_zero", 32'(exp_delay), 32'd24);
    send_frame(1'b0);
    wait_result("len2");
    check_image("len2_mem");
    chk("len2_instr1", {tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]}, 32'h12345678);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
